// File: rtl/seq1101_pkg.sv
// -----------------------------------------------------------------------------
// seq1101_pkg
// Shared definitions for the "1101" stream controller and its bit-serial
// detector core:
//   det_state_e  - detector state encodings S0..S3 (3-bit, status output)
//   ctrl_state_e - controller FSM encodings IDLE / SHIFT / REPORT
//   TOTAL_MAX    - saturation ceiling of the running match total
//   sat_inc16    - saturating increment used for the running total
// -----------------------------------------------------------------------------
package seq1101_pkg;

  // Detector states: each one records how much of "1101" has been seen.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // nothing useful seen
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3   // "110"
  } det_state_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } ctrl_state_e;

  localparam logic [15:0] TOTAL_MAX = 16'hFFFF;

  // Increment that sticks at TOTAL_MAX instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] next_value;
    if (value == TOTAL_MAX) begin
      next_value = TOTAL_MAX;
    end else begin
      next_value = value + 16'd1;
    end
    return next_value;
  endfunction

endpackage

// File: rtl/mealy1101_core.sv
// -----------------------------------------------------------------------------
// mealy1101_core
// Bit-serial Mealy detector for overlapping "1101".
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset (state -> S0)
//   clr    in   force state to S0 on this edge (takes priority over en)
//   en     in   advance the detector with 'in' on this edge
//   in     in   current serial bit
//   status out  present detector state (S0..S3)
//   result out  match strobe: present state S3 and current bit 1 while enabled
// -----------------------------------------------------------------------------
module mealy1101_core
  import seq1101_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       in,
  output logic [2:0] status,
  output logic       result
);

  det_state_e state_q;
  det_state_e state_d;

  // Detector state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Detector next-state logic; state is held whenever en is low.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S0;
    end else if (en) begin
      case (state_q)
        S0:      state_d = in ? S1 : S0;
        S1:      state_d = in ? S2 : S0;
        S2:      state_d = in ? S2 : S3;
        // A completed match leaves a trailing "1", which is the start of
        // the next possible match (overlap).
        S3:      state_d = in ? S1 : S0;
        default: state_d = S0;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Mealy output: depends on present state and the current bit.
  always_comb begin
    result = 1'b0;
    if (en && (state_q == S3) && in) begin
      result = 1'b1;
    end else begin
      result = 1'b0;
    end
  end

  assign status = state_q;

endmodule

// File: rtl/seq1101_stream_ctrl.sv
// -----------------------------------------------------------------------------
// seq1101_stream_ctrl
// Accepts W-bit words over a valid/ready handshake, streams them MSB-first
// through a shared "1101" Mealy detector (one bit per clock), and returns the
// number of matches ending inside each word over a second valid/ready
// handshake. A saturating 16-bit total of all matches is kept as well.
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    word handshake; in_ready is high only in IDLE
//   in_data[W-1:0]       word, bit W-1 is sent first
//   in_carry             1: keep detector history from the previous word
//                        0: restart the detector at S0 on the accept edge
//   out_valid/out_ready  count handshake; out_valid is high only in REPORT
//   out_count[CW-1:0]    matches ending inside the word
//   total[15:0]          saturating count of all matches since reset
//   result               detector match strobe for the bit being presented
//   status[2:0]          detector present state
// -----------------------------------------------------------------------------
module seq1101_stream_ctrl
  import seq1101_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_carry,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic [15:0]   total,
  output logic          result,
  output logic [2:0]    status
);

  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  ctrl_state_e   ctrl_q;
  ctrl_state_e   ctrl_d;
  logic [W-1:0]  data_q;
  logic [W-1:0]  data_d;
  logic [CW-1:0] idx_q;
  logic [CW-1:0] idx_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [15:0]   total_q;
  logic [15:0]   total_d;

  logic          accept_s;
  logic          det_en_s;
  logic          det_clr_s;
  logic          det_bit_s;
  logic          det_result_s;
  logic [2:0]    det_status_s;

  // Controller state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      total_q <= 16'h0000;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
    end
  end

  // Controller next-state logic.
  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      IDLE: begin
        if (in_valid) begin
          ctrl_d = SHIFT;
        end else begin
          ctrl_d = IDLE;
        end
      end
      SHIFT: begin
        if (idx_q == LAST_IDX) begin
          ctrl_d = REPORT;
        end else begin
          ctrl_d = SHIFT;
        end
      end
      REPORT: begin
        if (out_ready) begin
          ctrl_d = IDLE;
        end else begin
          ctrl_d = REPORT;
        end
      end
      default: ctrl_d = IDLE;
    endcase
  end

  // Controller outputs and detector control strobes.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept_s  = 1'b0;
    det_en_s  = 1'b0;
    det_clr_s = 1'b0;
    case (ctrl_q)
      IDLE: begin
        // Held low while reset is asserted so no word is taken during reset.
        in_ready  = ~reset;
        accept_s  = in_valid;
        det_clr_s = in_valid & ~in_carry;
      end
      SHIFT: begin
        det_en_s = 1'b1;
      end
      REPORT: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: word shift register, bit index, per-word and running counts.
  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    if (accept_s) begin
      data_d = in_data;
      idx_d  = '0;
      cnt_d  = '0;
    end else if (ctrl_q == SHIFT) begin
      // Shifting left keeps the bit being presented at data_q[W-1].
      data_d = {data_q[W-2:0], 1'b0};
      idx_d  = idx_q + CW'(1);
      if (det_result_s) begin
        cnt_d   = cnt_q + CW'(1);
        total_d = sat_inc16(total_q);
      end else begin
        cnt_d   = cnt_q;
        total_d = total_q;
      end
    end else begin
      data_d  = data_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      total_d = total_q;
    end
  end

  assign det_bit_s = data_q[W-1];

  mealy1101_core u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (det_clr_s),
    .en     (det_en_s),
    .in     (det_bit_s),
    .status (det_status_s),
    .result (det_result_s)
  );

  assign out_count = cnt_q;
  assign total     = total_q;
  assign result    = det_result_s;
  assign status    = det_status_s;

endmodule

// File: tb/tb_seq1101_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq1101_stream_ctrl
// Self-checking bench: a driver issues words and pushes the expected count of
// each into a scoreboard queue; a monitor pops and compares whenever a count
// is handed over (out_valid && out_ready). Expected values come from a model
// that treats the input as a bit string and counts "1101" windows.
// -----------------------------------------------------------------------------
module tb_seq1101_stream_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic [15:0]   total;
  logic          result;
  logic [2:0]    status;

  int checks;
  int errors;
  int exp_q[$];

  // Reference model state: last three bits of the stream since the last
  // detector restart, and the running total.
  bit hist[$];
  int model_total;

  seq1101_stream_ctrl #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .total     (total),
    .result    (result),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each handed-over count against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_report: got count %0d with no word pending", out_count);
      end else begin
        check("out_count", 32'(out_count), 32'(exp_q.pop_front()));
      end
    end
  end

  // Issue one word, check it bit by bit, hold REPORT for 'hold' cycles.
  task automatic send_word(input logic [W-1:0] d, input logic c, input int hold);
    bit   stream[$];
    bit   er[W];
    int   base;
    int   ecnt;
    int   n;
    int   p;
    logic [2:0] est;

    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready stayed %0b for %0d cycles", in_ready, n);
      return;
    end

    // Model: count "1101" windows that end inside this word.
    if (c) stream = hist;
    else   stream = {};
    base = stream.size();
    for (int i = 0; i < W; i++) stream.push_back(d[W-1-i]);
    ecnt = 0;
    for (int i = 0; i < W; i++) begin
      p = base + i;
      er[i] = (p >= 3) && stream[p-3] && stream[p-2] && !stream[p-1] && stream[p];
      if (er[i]) begin
        ecnt++;
        model_total = (model_total < 65535) ? model_total + 1 : 65535;
      end
    end
    hist.delete();
    for (int i = stream.size() - 3; i < stream.size(); i++) hist.push_back(stream[i]);
    // Detector state = longest stream suffix that is a prefix of "1101".
    if (hist[0] && hist[1] && !hist[2]) est = 3'd3;
    else if (hist[1] && hist[2])        est = 3'd2;
    else if (hist[2])                   est = 3'd1;
    else                                est = 3'd0;
    exp_q.push_back(ecnt);

    in_valid  = 1'b1;
    in_data   = d;
    in_carry  = c;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_carry = 1'($urandom);

    for (int i = 0; i < W; i++) begin
      check("result_bit", 32'(result), 32'(er[i]));
      check("busy_flags", 32'({in_ready, out_valid}), 32'(2'b00));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b0;
    check("report_valid", 32'(out_valid), 32'(1'b1));
    check("status_end", 32'(status), 32'(est));
    check("total", 32'(total), 32'(model_total));
    for (int h = 0; h < hold; h++) begin
      check("hold_count", 32'(out_count), 32'(ecnt));
      check("hold_flags", 32'({in_ready, out_valid}), 32'(2'b01));
      in_valid = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_flags", 32'({in_ready, out_valid, result}), 32'(3'b100));
    check("count_held", 32'(out_count), 32'(ecnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks      = 0;
    errors      = 0;
    model_total = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_carry    = 1'b0;
    out_ready   = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'(1'b0));
    check("rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("rst_count", 32'(out_count), 32'(0));
    check("rst_total", 32'(total), 32'(0));
    check("rst_status", 32'(status), 32'(0));
    check("rst_result", 32'(result), 32'(1'b0));
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'(1'b1));

    // Directed words.
    send_word(8'b1101_1010, 1'b0, 0);
    send_word(8'b0110_1101, 1'b0, 0);
    send_word(8'hFF,        1'b0, 0);
    send_word(8'b0000_0110, 1'b0, 0);
    send_word(8'b1000_0000, 1'b1, 0);
    send_word(8'b0000_0110, 1'b0, 0);
    send_word(8'b1000_0000, 1'b0, 5);

    // Reset in SHIFT while bit 4 of the word is being presented.
    in_valid = 1'b1;
    in_data  = 8'b1101_1101;
    in_carry = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("abort_total_pre", 32'(total), 32'(model_total + 1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_flags", 32'({in_ready, out_valid}), 32'(2'b10));
    check("abort_total", 32'(total), 32'(0));
    check("abort_status", 32'(status), 32'(0));
    model_total = 0;
    hist.delete();
    out_ready = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      check("abort_no_report", 32'(out_valid), 32'(1'b0));
      tick();
    end
    out_ready = 1'b0;

    // Randomized words.
    for (int k = 0; k < 30; k++) begin
      send_word(W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Saturation of the running total.
    force dut.total_q = 16'hFFFE;
    tick();
    release dut.total_q;
    model_total = 16'hFFFE;
    check("preload_total", 32'(total), 32'(16'hFFFE));
    send_word(8'b1101_1010, 1'b0, 0);
    send_word(8'b1101_1101, 1'b1, 1);

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq1101_stream_ctrl.md
# seq1101_stream_ctrl

Controller that time-shares one serial "1101" Mealy detector across a stream of parallel words. It accepts a W-bit word over a valid/ready handshake and feeds its bits to the detector MSB-first, one per clock. It counts overlapping matches within the word and returns the count over a second valid/ready handshake. It sits between a word-oriented producer/consumer and the bit-serial detector datapath, and also keeps a saturating running total of all matches.

## Interface
Parameters:
- W, 8, word width in bits (W >= 4).
- CW, $clog2(W+1), width of the per-word match count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  producer has a word.
- in_ready  output  1  controller can accept a word.
- in_data  input  W  word, bit W-1 is sent first.
- in_carry  input  1  sampled with the word: 1 keeps detector history from the previous word; 0 restarts the detector at S0.
- out_valid  output  1  per-word count available.
- out_ready  input  1  consumer takes the count.
- out_count  output  CW  overlapping "1101" matches ending inside the word.
- total  output  16  saturating count of all matches since reset.
- result  output  1  Mealy match strobe from the detector, for the current bit.
- status  output  3  detector present state, for debug.

## Operation
- Controller FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_data and in_carry, clear bit index and out_count, then go to SHIFT.
  - If in_carry=0, the detector is forced to S0 on the same edge.
- SHIFT:
  - in_ready=0.
  - Each cycle, present in_data[W-1-idx] to the detector.
  - The detector advances on the edge.
  - If result=1, increment out_count and total (total saturates at 16'hFFFF).
  - After bit idx=W-1 is processed, go to REPORT.
- REPORT:
  - out_valid=1 and out_count stays stable.
  - On out_ready, go to IDLE. out_count holds its value until the next accept.
- Detector states (Mealy, overlapping detection):
  - S0 (none): 1→S1, 0→S0.
  - S1 ("1"): 1→S2, 0→S0.
  - S2 ("11"): 1→S2, 0→S3.
  - S3 ("110"): 1→S1 with result=1, 0→S0.
  - result is combinational from the present state and the current bit, and is 0 outside SHIFT.
- Detector state is held in IDLE and REPORT, so it carries over between words when in_carry=1.
- Width rule: out_count cannot exceed floor((W-1)/3)+1, which always fits in CW.

## Timing
- Reset values: in_ready=0 during reset, then 1 in the first cycle after reset in IDLE. out_valid=0, out_count=0, total=0, status=S0, result=0, FSM=IDLE.
- Latency: with the accept on edge k, out_valid is high from edge k+W onward, and the count includes the last bit's match.
- Throughput: one word per W+2 cycles at best (accept edge, W shift edges, report edge with out_ready=1, then IDLE).
- in_valid outside IDLE is ignored. in_data and in_carry only need to be stable on the accept edge.
- out_ready outside REPORT is ignored. In REPORT with out_ready=0, the FSM holds indefinitely.
- Reset asserted mid-word (SHIFT or REPORT): any word in flight is discarded, all state returns to reset values on the next edge, and there is no out_valid for that word.

## Structure
- Shared package seq1101_pkg holds:
  - detector state encodings S0..S3 (3-bit, S0=3'd0 … S3=3'd3);
  - controller state encodings IDLE/SHIFT/REPORT;
  - the TOTAL_MAX=16'hFFFF constant.
- Sub-module mealy1101_core: inputs clk, reset, clr (force S0), en (advance), in; outputs status[2:0], result. The controller drives en only in SHIFT and clr on the accept edge when in_carry=0.

## Test plan
- Reset, then accept 8'b1101_1010 with in_carry=0 → out_valid after 8 edges, out_count=2, total=2, two result pulses on bits 3 and 6.
- Accept 8'b0110_1101 with in_carry=0 → out_count=2. Then accept 8'hFF with in_carry=0 → out_count=0, total unchanged.
- Accept 8'b0000_0110, then 8'b1000_0000 with in_carry=1 → second out_count=1. Repeat the pair with in_carry=0 → second out_count=0.
- Hold out_ready=0 for 5 cycles in REPORT while toggling in_valid → out_count stable, in_ready=0, no extra accept. Then out_ready=1 → IDLE next cycle.
- Assert reset during SHIFT at bit 4 of 8'b1101_1101 → the next cycle shows out_valid=0, total=0, status=S0, in_ready=1, and no report for that word.
- Preload total to 16'hFFFE by forcing, then send 8'b1101_1010 → total=16'hFFFF (saturated), out_count=2.
